// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus debounce FSM producing a clean registered level.
// Optional BTN_AUTO_REPEAT_EN adds a hold-to-repeat strobe on rpt_pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_db,
  output logic busy,
  output logic rpt_pulse
);
  typedef enum logic [1:0] {IDLE, WAIT_HI, HIGH, WAIT_LO} state_t;
  state_t state;
  logic s1, s2, done;
  logic [CNT_W-1:0] cnt;
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << CNT_W) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad
    $error("btn_debounce: illegal parameters");
  end
  assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  // btn_db and busy are written alongside the state so they are registered copies of it
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      btn_db <= 1'b0;
      busy <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      case (state)
        IDLE: if (s2) begin
          state <= WAIT_HI;
          cnt <= '0;
          busy <= 1'b1;
        end
        WAIT_HI: if (!s2) begin
          state <= IDLE;
          cnt <= '0;
          busy <= 1'b0;
        end else if (done) begin
          state <= HIGH;
          cnt <= '0;
          busy <= 1'b0;
          btn_db <= 1'b1;
        end else cnt <= cnt + 1'b1;
        HIGH: if (!s2) begin
          state <= WAIT_LO;
          cnt <= '0;
          busy <= 1'b1;
        end
        WAIT_LO: if (s2) begin
          state <= HIGH;
          cnt <= '0;
          busy <= 1'b0;
        end else if (done) begin
          state <= IDLE;
          cnt <= '0;
          busy <= 1'b0;
          btn_db <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rcnt;
  logic armed, rhit;
  assign rhit = rcnt == (armed ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  // WAIT_LO holds the count so a bounce during a long press does not restart the delay
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      armed <= 1'b0;
      rpt_pulse <= 1'b0;
    end else begin
      rpt_pulse <= state == HIGH && rhit;
      if (state == HIGH) begin
        rcnt <= rhit ? '0 : rcnt + 1'b1;
        armed <= armed | rhit;
      end else if (state != WAIT_LO) begin
        rcnt <= '0;
        armed <= 1'b0;
      end
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: random and directed button stimulus on two instances (4-cycle and 1-cycle filters), scoreboarded against a run-length model.
module tb_btn_debounce;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int DC [2] = '{4, 1};
  typedef struct packed {
    logic [1:0] db;
    logic [1:0] busy;
    logic [1:0] rpt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic [1:0] db, busy, rpt;
  int checks = 0;
  int errors = 0;
  exp_t q [$];
  btn_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u0 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_db(db[0]), .busy(busy[0]), .rpt_pulse(rpt[0]));
  btn_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(2), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u1 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_db(db[1]), .busy(busy[1]), .rpt_pulse(rpt[1]));
  always #5 clk = ~clk;
  // Model: the level flips once DC+1 consecutive synchronised samples disagree with it.
  logic p1 = 1'b0, p2 = 1'b0;
  logic m_db [2] = '{1'b0, 1'b0};
  logic m_busy [2] = '{1'b0, 1'b0};
  logic m_rpt [2] = '{1'b0, 1'b0};
  int run [2] = '{0, 0};
  int hc [2] = '{0, 0};
  always @(posedge clk) begin
    exp_t e;
    logic samp, pdb, phigh;
    if (rst) begin
      p1 = 1'b0;
      p2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_db[k] = 1'b0;
        m_busy[k] = 1'b0;
        m_rpt[k] = 1'b0;
        run[k] = 0;
        hc[k] = 0;
      end
    end else begin
      samp = p2;
      for (int k = 0; k < 2; k++) begin
        pdb = m_db[k];
        phigh = m_db[k] && !m_busy[k];
        run[k] = (samp != m_db[k]) ? run[k] + 1 : 0;
        if (run[k] == DC[k] + 1) begin
          m_db[k] = !m_db[k];
          run[k] = 0;
        end
        m_busy[k] = samp != m_db[k];
        m_rpt[k] = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        if (phigh) begin
          hc[k]++;
          m_rpt[k] = hc[k] == RD || (hc[k] > RD && (hc[k] - RD) % RP == 0);
        end else if (!pdb) hc[k] = 0;
`else
        if (phigh && !pdb) hc[k] = 0;
`endif
      end
      p2 = p1;
      p1 = btn_in;
    end
    for (int k = 0; k < 2; k++) begin
      e.db[k] = m_db[k];
      e.busy[k] = m_busy[k];
      e.rpt[k] = m_rpt[k];
    end
    q.push_back(e);
  end
  task automatic chk(input string nm, input int k, input logic a, input logic x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s[D=%0d] at %0t: got %b expected %b", nm, DC[k], $time, a, x);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int k = 0; k < 2; k++) begin
        chk("btn_db", k, db[k], e.db[k]);
        chk("busy", k, busy[k], e.busy[k]);
        chk("rpt_pulse", k, rpt[k], e.rpt[k]);
      end
    end
  end
  task automatic hold(input logic v, input int n);
    btn_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hold(0, 3);
    hold(1, 12);
    hold(0, 10);
    hold(1, 3);
    hold(0, 10);
    hold(1, 12);
    for (int i = 0; i < 5; i++) begin
      hold(1, 2);
      hold(0, 2);
    end
    hold(0, 12);
    hold(1, 12);
    rst = 1'b1;
    hold(1, 3);
    rst = 1'b0;
    hold(1, 12);
    hold(1, 30);
    hold(0, 2);
    hold(1, 20);
    hold(0, 10);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        rst = 1'b0;
      end
      hold(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 6));
    end
    hold(0, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
